// File: rtl/rv32_mod_mem_arbiter.sv
// rv32_mod_mem_arbiter: round-robin arbiter that shares one memory port between
// the instruction and data requesters, with a per-transaction response timeout.
`default_nettype none

module rv32_mod_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  // instruction side
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_ack,
  output logic        instr_err,
  output logic [31:0] instr_data_o,
  // data side
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_wdata,
  output logic        data_ack,
  output logic        data_err,
  output logic [31:0] data_rdata,
  // memory side
  output logic        mem_req,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      state_next;
  logic [15:0] timeout_count;
  logic        last_data;
  logic        busy;
  logic        timed_out;
  logic        resp_ack;
  logic        resp_err;
  logic        grant_data;
  logic        grant_instr;

  assign busy      = (state == BUSY_I) || (state == BUSY_D);
  // A real memory response in the limit cycle takes precedence over the timeout.
  assign timed_out = busy && (timeout_count == TIMEOUT_LIMIT) && !mem_ack && !mem_err;
  assign resp_err  = busy && (mem_err || timed_out);
  assign resp_ack  = busy && mem_ack && !mem_err;

  // On contention the requester not served last wins; last_data resets to 0 so data goes first.
  assign grant_data  = data_req && (!instr_req || !last_data);
  assign grant_instr = instr_req && !grant_data;

  assign instr_ack    = (state == BUSY_I) && resp_ack;
  assign instr_err    = (state == BUSY_I) && resp_err;
  assign instr_data_o = instr_ack ? mem_rdata : 32'h0;
  assign data_ack     = (state == BUSY_D) && resp_ack;
  assign data_err     = (state == BUSY_D) && resp_err;
  assign data_rdata   = data_ack ? mem_rdata : 32'h0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_data) begin
          state_next = BUSY_D;
        end else if (grant_instr) begin
          state_next = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (resp_ack || resp_err) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req       <= 1'b0;
      mem_wr        <= 1'b0;
      mem_addr      <= 32'h0;
      mem_be        <= 4'h0;
      mem_wdata     <= 32'h0;
      timeout_count <= 16'h0;
      last_data     <= 1'b0;
    end else begin
      mem_req <= (state_next == BUSY_I) || (state_next == BUSY_D);

      // Request fields are captured only on the grant edge and then held.
      if (state == IDLE) begin
        if (grant_data) begin
          mem_wr    <= data_wr;
          mem_addr  <= data_addr;
          mem_be    <= data_be;
          mem_wdata <= data_wdata;
          last_data <= 1'b1;
        end else if (grant_instr) begin
          mem_wr    <= 1'b0;
          mem_addr  <= instr_addr;
          mem_be    <= 4'hF;
          mem_wdata <= 32'h0;
          last_data <= 1'b0;
        end
      end

      if (state == IDLE) begin
        timeout_count <= 16'h0;
      end else if (busy && !mem_ack && !mem_err && (timeout_count != TIMEOUT_LIMIT)) begin
        timeout_count <= timeout_count + 16'h1;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/rv32_mod_mem_arbiter.md
RV32_MOD_MEM_ARBITER -- requirements
Module: rv32_mod_mem_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles waited for mem_ack/mem_err, legal range 1..65535.
REQ-002 The module SHALL have port clk, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have instruction-side ports: instr_req in 1, instr_addr in 32, instr_ack out 1, instr_err out 1, instr_data_o out 32.
REQ-005 The module SHALL have data-side ports: data_req in 1, data_wr in 1, data_addr in 32, data_be in 4, data_wdata in 32, data_ack out 1, data_err out 1, data_rdata out 32.
REQ-006 The module SHALL have memory-side ports: mem_req out 1, mem_wr out 1, mem_addr out 32, mem_be out 4, mem_wdata out 32, mem_ack in 1, mem_err in 1, mem_rdata in 32.

Function
REQ-007 The module SHALL implement states IDLE, BUSY_I, BUSY_D and DONE.
REQ-008 In IDLE with exactly one of instr_req/data_req high, the module SHALL enter BUSY_I or BUSY_D on the next edge.
REQ-009 In IDLE with both requests high, the module SHALL grant the requester not granted last; after reset, data wins first.
REQ-010 The grant edge SHALL register mem_addr, mem_wr, mem_be and mem_wdata from the winner; instruction grants use mem_wr=0 and mem_be=4'hF.
REQ-011 mem_req SHALL be a registered output: 1 exactly while in BUSY_I or BUSY_D, 0 otherwise.
REQ-012 mem_addr, mem_wr, mem_be and mem_wdata SHALL stay stable for the whole BUSY state, regardless of requester input changes.
REQ-013 In BUSY_x, mem_ack=1 SHALL drive x_ack=1 combinationally in the same cycle, pass mem_rdata to x's data output, and move to DONE.
REQ-014 In BUSY_x, mem_err=1 SHALL drive x_err=1 combinationally and move to DONE; if mem_ack and mem_err are both high, err wins and ack stays 0.
REQ-015 A non-granted requester SHALL see ack=0, err=0 and data output 32'h0.
REQ-016 DONE SHALL last exactly one cycle with mem_req=0, then return to IDLE; minimum issue-to-issue spacing is 3 cycles.
REQ-017 A timeout counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ack/mem_err.
REQ-018 When the counter reaches TIMEOUT_CYCLES, the module SHALL assert the granted requester's err for one cycle and move to DONE.
REQ-019 The counter SHALL saturate and never wrap.
REQ-020 A requester dropping req during BUSY SHALL NOT abort the transaction; the response is still signalled and the requester ignores it.
REQ-021 A requester holding req after its ack SHALL be treated as a new request in the next IDLE cycle, subject to round-robin.
REQ-022 mem_ack or mem_err arriving in IDLE or DONE SHALL be ignored and SHALL NOT drive any requester ack/err.
REQ-023 The last-granted flag SHALL update only on the grant edge.

Reset
REQ-024 Asserting reset SHALL immediately force state IDLE, mem_req=0, mem_wr=0, mem_addr=0, mem_be=0, mem_wdata=0, timeout counter=0 and last-granted=instruction.
REQ-025 All requester ack/err outputs SHALL be 0 during reset.
REQ-026 Reset during BUSY SHALL drop mem_req asynchronously and discard the in-flight transaction.
REQ-027 After reset deassertion, the first grant SHALL occur on the first edge where a request is seen in IDLE.

Verification
REQ-028 Bench SHALL cover: instr_req only, instr_addr=32'h100, mem_ack after 2 BUSY cycles with mem_rdata=32'h00000013 -> mem_req=1 for 3 cycles, mem_addr=32'h100, mem_be=4'hF, instr_ack=1 and instr_data_o=32'h13 in the ack cycle.
REQ-029 Bench SHALL cover: instr_req and data_req both held high from reset, memory acking every BUSY cycle -> grant order D, I, D, I, with mem_req high every 3rd cycle.
REQ-030 Bench SHALL cover: data_req with data_wr=1, data_be=4'b0011, data_wdata=32'hDEADBEEF, while data_wdata changes during BUSY -> mem_wdata stays 32'hDEADBEEF and mem_wr=1 until data_ack.
REQ-031 Bench SHALL cover: TIMEOUT_CYCLES=4 with memory never responding -> data_err=1 on the 5th BUSY cycle, then DONE, then IDLE.
REQ-032 Bench SHALL cover: mem_ack=1 and mem_err=1 in the same BUSY_I cycle -> instr_err=1 and instr_ack=0.
REQ-033 Bench SHALL cover: reset asserted mid-BUSY_D -> mem_req=0 before the next clk edge, and data_ack never asserted for that transaction.
